// File: rtl/br_write_arbiter_pkg.sv
// Shared types for the register-bank write arbiter: default widths,
// scheduler state and the queued write request.
package br_write_arbiter_pkg;

  localparam int BR_AW = 5;
  localparam int BR_DW = 32;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [BR_AW-1:0] addr;
    logic [BR_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/br_wb_fifo.sv
// Per-requester writeback FIFO; head visible the cycle after push.
// ready is a function of count only, so a full FIFO refuses a push even while popping.
module br_wb_fifo
  import br_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = BR_AW,
  parameter int DW    = BR_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     ready,
  output logic                     not_empty,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [DEPTH-1:0]         ent_vld,
  output logic [DEPTH-1:0][AW-1:0] ent_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign ready     = count < (PW+1)'(DEPTH);
  assign not_empty = count != '0;
  assign push_ok   = push && ready;
  assign pop_ok    = pop && not_empty;
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  // Storage needs no reset: validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    ent_vld  = '0;
    ent_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]  = {1'b0, PW'(i) - rd_ptr} < count;
      ent_addr[i] = addr_q[i];
    end
  end

endmodule

// File: rtl/br_write_arbiter.sv
// Round-robin arbiter draining two writeback FIFOs into the bank's single write port.
// Accept at edge N, head in cycle N+1, we=1 in cycle N+2; each requester backpressured by its own FIFO.
module br_write_arbiter
  import br_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = BR_AW,
  parameter int DW    = BR_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic [AW-1:0]      a_addr,
  input  logic [DW-1:0]      a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [AW-1:0]      b_addr,
  input  logic [DW-1:0]      b_data,
  output logic               b_ready,
  output logic [AW-1:0]      wa,
  output logic [DW-1:0]      data_in,
  output logic               we,
  output logic [(1<<AW)-1:0] pending_mask
);

  sched_state_t            state;
  logic                    a_ne;
  logic                    b_ne;
  logic [AW-1:0]           a_head_addr;
  logic [AW-1:0]           b_head_addr;
  logic [DW-1:0]           a_head_data;
  logic [DW-1:0]           b_head_data;
  logic [DEPTH-1:0]        a_ent_vld;
  logic [DEPTH-1:0]        b_ent_vld;
  logic [DEPTH-1:0][AW-1:0] a_ent_addr;
  logic [DEPTH-1:0][AW-1:0] b_ent_addr;
  logic                    grant_a;
  logic                    grant_b;
  logic [AW-1:0]           sel_addr;
  logic [DW-1:0]           sel_data;

  br_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_valid),
    .push_addr (a_addr),
    .push_data (a_data),
    .pop       (grant_a),
    .ready     (a_ready),
    .not_empty (a_ne),
    .head_addr (a_head_addr),
    .head_data (a_head_data),
    .ent_vld   (a_ent_vld),
    .ent_addr  (a_ent_addr)
  );

  br_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_valid),
    .push_addr (b_addr),
    .push_data (b_data),
    .pop       (grant_b),
    .ready     (b_ready),
    .not_empty (b_ne),
    .head_addr (b_head_addr),
    .head_data (b_head_data),
    .ent_vld   (b_ent_vld),
    .ent_addr  (b_ent_addr)
  );

  assign grant_a  = a_ne && (!b_ne || state == PRIO_A);
  assign grant_b  = b_ne && !grant_a;
  assign sel_addr = grant_a ? a_head_addr : b_head_addr;
  assign sel_data = grant_a ? a_head_data : b_head_data;

  // Address-0 writes are popped like any other but never enable the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PRIO_A;
      we      <= 1'b0;
      wa      <= '0;
      data_in <= '0;
    end else if (grant_a || grant_b) begin
      wa      <= sel_addr;
      data_in <= sel_data;
      we      <= sel_addr != '0;
      state   <= grant_a ? PRIO_B : PRIO_A;
    end else begin
      we <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_vld[i]) pending_mask[a_ent_addr[i]] = 1'b1;
      if (b_ent_vld[i]) pending_mask[b_ent_addr[i]] = 1'b1;
    end
    if (we) pending_mask[wa] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_br_write_arbiter.sv
// Directed bench for br_write_arbiter: latency, round-robin order, backpressure,
// address-0 drop, same-address race and mid-stream reset.
module tb_br_write_arbiter;
  import br_write_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic [4:0]  wa;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] pending_mask;

  int n_checks = 0;
  int n_errors = 0;

  wr_req_t     qa[$];
  wr_req_t     qb[$];
  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [4:0]  sub_a[$];
  logic [4:0]  sub_b[$];
  logic [31:0] bank [32];
  logic [4:0]  exp_c [6];

  br_write_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .wa           (wa),
    .data_in      (data_in),
    .we           (we),
    .pending_mask (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: a write enabled during a cycle commits at the closing edge.
  always @(posedge clk) begin
    if (we) begin
      log_addr.push_back(wa);
      log_data.push_back(data_in);
      bank[wa] <= data_in;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] log_at(input int i);
    return (i < log_addr.size()) ? 64'(log_addr[i]) : 64'hFFFF;
  endfunction

  task automatic drive();
    a_valid = qa.size() > 0;
    b_valid = qb.size() > 0;
    if (a_valid) begin a_addr = qa[0].addr; a_data = qa[0].data; end
    if (b_valid) begin b_addr = qb[0].addr; b_data = qb[0].data; end
  endtask

  task automatic step();
    logic acc_a, acc_b;
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (acc_a) qa.delete(0);
    if (acc_b) qb.delete(0);
    drive();
  endtask

  task automatic push_a(input logic [4:0] ad, input logic [31:0] d);
    wr_req_t r;
    r.addr = ad; r.data = d;
    qa.push_back(r);
  endtask

  task automatic push_b(input logic [4:0] ad, input logic [31:0] d);
    wr_req_t r;
    r.addr = ad; r.data = d;
    qb.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qa.delete();
    qb.delete();
    drive();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_bound", 64'(n < 200), 64'd1);
    repeat (6) step();
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    for (int i = 0; i < 32; i++) bank[i] = '0;

    // Reset state
    do_reset();
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_b_ready", 64'(b_ready), 64'd1);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wa", 64'(wa), 64'd0);
    chk("rst_data_in", 64'(data_in), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);

    // Single write: accepted at edge 0, bank write in cycle 2
    push_a(5'd5, 32'hDEADBEEF);
    drive();
    step();
    chk("single_mask_c1", 64'(pending_mask), 64'h20);
    chk("single_we_c1", 64'(we), 64'd0);
    step();
    chk("single_we_c2", 64'(we), 64'd1);
    chk("single_wa_c2", 64'(wa), 64'd5);
    chk("single_data_c2", 64'(data_in), 64'hDEADBEEF);
    chk("single_mask_c2", 64'(pending_mask), 64'h20);
    step();
    chk("single_mask_c3", 64'(pending_mask), 64'd0);
    chk("single_we_c3", 64'(we), 64'd0);

    // Contention: strict alternation starting with A
    do_reset();
    push_a(5'd1, 32'h101); push_b(5'd9, 32'h109);
    push_a(5'd2, 32'h102); push_b(5'd10, 32'h10A);
    push_a(5'd3, 32'h103); push_b(5'd11, 32'h10B);
    drive();
    drain();
    exp_c[0] = 5'd1; exp_c[1] = 5'd9;  exp_c[2] = 5'd2;
    exp_c[3] = 5'd10; exp_c[4] = 5'd3; exp_c[5] = 5'd11;
    chk("cont_count", 64'(log_addr.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("cont_order%0d", i), log_at(i), 64'(exp_c[i]));

    // Backpressure on B while A keeps the bank busy
    do_reset();
    push_a(5'd1, 32'hA1); push_a(5'd2, 32'hA2); push_a(5'd3, 32'hA3); push_a(5'd4, 32'hA4);
    push_b(5'd20, 32'hB0); push_b(5'd21, 32'hB1); push_b(5'd22, 32'hB2);
    drive();
    step();
    chk("bp_b_ready_c1", 64'(b_ready), 64'd1);
    step();
    chk("bp_b_ready_c2", 64'(b_ready), 64'd0);
    drain();
    sub_a.delete();
    sub_b.delete();
    foreach (log_addr[i]) begin
      if (log_addr[i] >= 5'd20) sub_b.push_back(log_addr[i]);
      else sub_a.push_back(log_addr[i]);
    end
    chk("bp_b_count", 64'(sub_b.size()), 64'd3);
    chk("bp_a_count", 64'(sub_a.size()), 64'd4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_b_order%0d", i), (i < sub_b.size()) ? 64'(sub_b[i]) : 64'hFFFF, 64'(20 + i));
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_a_order%0d", i), (i < sub_a.size()) ? 64'(sub_a[i]) : 64'hFFFF, 64'(1 + i));

    // Address 0 is consumed without enabling the bank
    do_reset();
    push_a(5'd0, 32'h1234);
    drive();
    step();
    chk("zero_mask_c1", 64'(pending_mask), 64'd0);
    step();
    chk("zero_we_c2", 64'(we), 64'd0);
    chk("zero_wa_c2", 64'(wa), 64'd0);
    chk("zero_data_c2", 64'(data_in), 64'h1234);
    chk("zero_mask_c2", 64'(pending_mask), 64'd0);
    step();
    chk("zero_a_ready_c3", 64'(a_ready), 64'd1);
    chk("zero_no_writes", 64'(log_addr.size()), 64'd0);

    // Same-address race: A first, B last, B's value survives
    do_reset();
    push_a(5'd7, 32'h11);
    push_b(5'd7, 32'h22);
    drive();
    step();
    chk("race_mask_c1", 64'(pending_mask), 64'h80);
    step();
    chk("race_we_c2", 64'(we), 64'd1);
    chk("race_data_c2", 64'(data_in), 64'h11);
    step();
    chk("race_data_c3", 64'(data_in), 64'h22);
    chk("race_mask_c3", 64'(pending_mask), 64'h80);
    step();
    chk("race_mask_c4", 64'(pending_mask), 64'd0);
    chk("race_r7", 64'(bank[7]), 64'h22);

    // Reset while FIFOs are loaded and a write is staged
    do_reset();
    push_a(5'd1, 32'h1); push_a(5'd2, 32'h2); push_a(5'd3, 32'h3); push_a(5'd4, 32'h4);
    push_b(5'd9, 32'h9); push_b(5'd10, 32'hA); push_b(5'd11, 32'hB); push_b(5'd12, 32'hC);
    drive();
    repeat (3) step();
    chk("mid_pre_we", 64'(we), 64'd1);
    chk("mid_pre_a_ready", 64'(a_ready), 64'd0);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    drive();
    @(posedge clk);
    #1;
    chk("mid_we", 64'(we), 64'd0);
    chk("mid_mask", 64'(pending_mask), 64'd0);
    chk("mid_a_ready", 64'(a_ready), 64'd1);
    chk("mid_b_ready", 64'(b_ready), 64'd1);
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
    push_a(5'd3, 32'h33);
    push_b(5'd4, 32'h44);
    drive();
    drain();
    chk("mid_first_grant", log_at(0), 64'd3);
    chk("mid_second_grant", log_at(1), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
